// File: rtl/pcie_bridge_pkg.sv
// pcie_bridge_pkg: FSM states, TLP codes, completion status codes and header field helpers
package pcie_bridge_pkg;

    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, CPL} state_t;

    localparam logic [1:0] TLP_MRD  = 2'b00;
    localparam logic [1:0] TLP_MWR  = 2'b01;
    localparam logic [7:0] TLP_CPL  = 8'b000_01010;
    localparam logic [7:0] TLP_CPLD = 8'b010_01010;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;
    localparam logic [2:0] CPL_CA = 3'b100;

    function automatic logic [2:0] hdr_fmt(input logic [127:0] h);
        return h[127:125];
    endfunction

    function automatic logic [4:0] hdr_type(input logic [127:0] h);
        return h[124:120];
    endfunction

    function automatic logic [9:0] hdr_len(input logic [127:0] h);
        return h[105:96];
    endfunction

    function automatic logic [15:0] hdr_reqid(input logic [127:0] h);
        return h[95:80];
    endfunction

    function automatic logic [7:0] hdr_tag(input logic [127:0] h);
        return h[79:72];
    endfunction

    function automatic logic [3:0] hdr_lbe(input logic [127:0] h);
        return h[71:68];
    endfunction

    function automatic logic [3:0] hdr_fbe(input logic [127:0] h);
        return h[67:64];
    endfunction

    function automatic logic [63:0] hdr_addr(input logic [127:0] h);
        return h[125] ? {h[63:32], h[31:2], 2'b00} : {32'h0, h[63:34], 2'b00};
    endfunction

    function automatic logic [4:0] hdr_lo(input logic [127:0] h);
        return h[125] ? h[6:2] : h[38:34];
    endfunction

    function automatic logic [1:0] be_lead(input logic [3:0] be);
        return be[0] ? 2'd0 : be[1] ? 2'd1 : be[2] ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [1:0] be_trail(input logic [3:0] be);
        return be[3] ? 2'd0 : be[2] ? 2'd1 : be[1] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/pcie_cpl_builder.sv
// pcie_cpl_builder: assembles completion header, realigned read data and DW strobes
module pcie_cpl_builder
    import pcie_bridge_pkg::*;
#(
    parameter int HDR_W  = 128,
    parameter int DATA_W = 256,
    parameter int STRB_W = 8
) (
    input  logic [HDR_W-1:0]  req_hdr_i,
    input  logic [2:0]        status_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [15:0]       completer_id_i,
    output logic [HDR_W-1:0]  cpl_hdr_o,
    output logic [DATA_W-1:0] cpl_data_o,
    output logic [STRB_W-1:0] cpl_strb_o
);

    logic        with_data;
    logic [9:0]  len;
    logic [3:0]  fbe;
    logic [4:0]  lo;
    logic [1:0]  lead;
    logic [1:0]  trail;
    logic [11:0] byte_cnt;
    logic        unused_hdr;

    assign unused_hdr = ^req_hdr_i;

    // only a successful read carries data; error completions are header-only
    always_comb begin
        with_data  = status_i == CPL_SC;
        len        = hdr_len(req_hdr_i);
        fbe        = hdr_fbe(req_hdr_i);
        lo         = hdr_lo(req_hdr_i);
        lead       = be_lead(fbe);
        trail      = len == 10'd1 ? be_trail(fbe) : be_trail(hdr_lbe(req_hdr_i));
        byte_cnt   = (len == 10'd1 && fbe == 4'h0) ? 12'd1 : {len, 2'b00} - 12'(lead) - 12'(trail);
        cpl_hdr_o  = {with_data ? TLP_CPLD : TLP_CPL, 14'h0, with_data ? len : 10'd0,
                      completer_id_i, status_i, 1'b0, byte_cnt,
                      hdr_reqid(req_hdr_i), hdr_tag(req_hdr_i), 1'b0, lo, lead,
                      32'h0};
        cpl_data_o = with_data ? rdata_i >> {lo[2:0], 5'b0} : '0;
        cpl_strb_o = '0;
        for (int i = 0; i < STRB_W; i++)
            cpl_strb_o[i] = with_data && (10'(i) < len);
    end

endmodule

// File: rtl/pcie_modport_bridge.sv
// pcie_modport_bridge: single-beat PCIe memory request TLPs to AXI4 master, read data back as completions
// Optional PCIE_BRIDGE_CXLIO_MCTP_EN adds a 1-deep MCTP packet buffer that shares the completion port.
module pcie_modport_bridge
    import pcie_bridge_pkg::*;
#(
    parameter int TLP_DATA_WIDTH = 256,
    parameter int TLP_HDR_WIDTH  = 128,
    parameter int TLP_STRB_WIDTH = 8,
    parameter int TLP_SEG_COUNT  = 1,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int AXI_STRB_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [TLP_DATA_WIDTH-1:0] rx_req_tlp_data_i,
    input  logic [TLP_HDR_WIDTH-1:0]  rx_req_tlp_hdr_i,
    input  logic [TLP_SEG_COUNT-1:0]  rx_req_tlp_valid_i,
    input  logic [TLP_SEG_COUNT-1:0]  rx_req_tlp_sop_i,
    input  logic [TLP_SEG_COUNT-1:0]  rx_req_tlp_eop_i,
    output logic                      rx_req_tlp_ready_o,
    output logic [TLP_DATA_WIDTH-1:0] tx_cpl_tlp_data_o,
    output logic [TLP_STRB_WIDTH-1:0] tx_cpl_tlp_strb_o,
    output logic [TLP_HDR_WIDTH-1:0]  tx_cpl_tlp_hdr_o,
    output logic [TLP_SEG_COUNT-1:0]  tx_cpl_tlp_valid_o,
    output logic [TLP_SEG_COUNT-1:0]  tx_cpl_tlp_sop_o,
    output logic [TLP_SEG_COUNT-1:0]  tx_cpl_tlp_eop_o,
    input  logic                      tx_cpl_tlp_ready_i,
    input  logic [15:0]               completer_id_i,
    input  logic [2:0]                max_payload_size_i,
`ifdef PCIE_BRIDGE_CXLIO_MCTP_EN
    input  logic [TLP_DATA_WIDTH-1:0] cxlio_mctp_req_data_i,
    input  logic [TLP_HDR_WIDTH-1:0]  cxlio_mctp_req_hdr_i,
    input  logic                      cxlio_mctp_en_i,
    input  logic [191:0]              cxlio_mctp_rsp_pkt_i,
`endif
    output logic                      status_error_cor_o,
    output logic                      status_error_uncor_o,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_awid_o,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr_o,
    output logic [7:0]                m_axi_awlen_o,
    output logic [2:0]                m_axi_awsize_o,
    output logic [1:0]                m_axi_awburst_o,
    output logic                      m_axi_awlock_o,
    output logic [3:0]                m_axi_awcache_o,
    output logic [2:0]                m_axi_awprot_o,
    output logic                      m_axi_awvalid_o,
    input  logic                      m_axi_awready_i,
    output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata_o,
    output logic [AXI_STRB_WIDTH-1:0] m_axi_wstrb_o,
    output logic                      m_axi_wlast_o,
    output logic                      m_axi_wvalid_o,
    input  logic                      m_axi_wready_i,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_bid_i,
    input  logic [1:0]                m_axi_bresp_i,
    input  logic                      m_axi_bvalid_i,
    output logic                      m_axi_bready_o,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid_o,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr_o,
    output logic [7:0]                m_axi_arlen_o,
    output logic [2:0]                m_axi_arsize_o,
    output logic [1:0]                m_axi_arburst_o,
    output logic                      m_axi_arlock_o,
    output logic [3:0]                m_axi_arcache_o,
    output logic [2:0]                m_axi_arprot_o,
    output logic                      m_axi_arvalid_o,
    input  logic                      m_axi_arready_i,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid_i,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata_i,
    input  logic [1:0]                m_axi_rresp_i,
    input  logic                      m_axi_rlast_i,
    input  logic                      m_axi_rvalid_i,
    output logic                      m_axi_rready_o
);

    localparam int AX_W = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 24;

    state_t                    state_q, state_d;
    logic                      ready_q, ready_d;
    logic [TLP_HDR_WIDTH-1:0]  hdr_q, hdr_d;
    logic [TLP_DATA_WIDTH-1:0] data_q, data_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]                status_q, status_d;
    logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                      cor_q, cor_d, uncor_q, uncor_d;

    logic [2:0]                rx_fmt;
    logic [9:0]                rx_len;
    logic [4:0]                rx_lo, q_lo;
    logic [9:0]                q_len;
    logic                      rx_accept, rx_ok, rx_posted;
    logic [AX_W-1:0]           ax_fields;
    logic [AXI_STRB_WIDTH-1:0] wstrb_c;
    logic                      cpl_sel, mctp_drop;
    logic [TLP_HDR_WIDTH-1:0]  cpl_hdr;
    logic [TLP_DATA_WIDTH-1:0] cpl_data;
    logic [TLP_STRB_WIDTH-1:0] cpl_strb;
    logic [TLP_HDR_WIDTH-1:0]  tx_hdr;
    logic [TLP_DATA_WIDTH-1:0] tx_data;
    logic [TLP_STRB_WIDTH-1:0] tx_strb;
    logic                      tx_valid;
    logic                      unused_ok;

    assign unused_ok = ^{hdr_q, q_lo, m_axi_bid_i, m_axi_rid_i, m_axi_rlast_i};

    assign rx_fmt    = hdr_fmt(rx_req_tlp_hdr_i);
    assign rx_len    = hdr_len(rx_req_tlp_hdr_i);
    assign rx_lo     = hdr_lo(rx_req_tlp_hdr_i);
    assign rx_posted = rx_fmt[1];
    assign rx_accept = rx_req_tlp_valid_i[0] & ready_q & rx_req_tlp_sop_i[0] & rx_req_tlp_eop_i[0];
    // a zero length field means 1024 DW, which is rejected along with everything above one beat
    assign rx_ok = (rx_fmt[2:1] == TLP_MRD || rx_fmt[2:1] == TLP_MWR) &&
                   hdr_type(rx_req_tlp_hdr_i) == 5'd0 && rx_len != 10'd0 && rx_len <= 10'd8 &&
                   (10'(rx_lo[2:0]) + rx_len) <= 10'd8 &&
                   16'({rx_len, 2'b00}) <= (16'd128 << max_payload_size_i);

    assign q_lo    = hdr_lo(hdr_q);
    assign q_len   = hdr_len(hdr_q);
    assign cpl_sel = state_q == CPL;

    // FSM next state, request capture and error pulse decisions
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        status_d  = status_q;
        aw_done_d = aw_done_q | (m_axi_awvalid_o & m_axi_awready_i);
        w_done_d  = w_done_q | (m_axi_wvalid_o & m_axi_wready_i);
        cor_d     = mctp_drop;
        uncor_d   = 1'b0;
        case (state_q)
            IDLE: if (rx_accept) begin
                hdr_d    = rx_req_tlp_hdr_i;
                data_d   = rx_req_tlp_data_i;
                status_d = rx_ok ? CPL_SC : CPL_UR;
                state_d  = rx_ok ? (rx_posted ? WR_ADDR_DATA : RD_ADDR) : (rx_posted ? IDLE : CPL);
                cor_d    = mctp_drop | (!rx_ok & !rx_posted);
                uncor_d  = !rx_ok & rx_posted;
            end
            WR_ADDR_DATA: if (aw_done_d && w_done_d) begin
                state_d   = WR_RESP;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
            WR_RESP: if (m_axi_bvalid_i) begin
                state_d = IDLE;
                uncor_d = m_axi_bresp_i != 2'b00;
            end
            RD_ADDR: state_d = m_axi_arready_i ? RD_DATA : RD_ADDR;
            RD_DATA: if (m_axi_rvalid_i) begin
                rdata_d  = m_axi_rdata_i;
                status_d = m_axi_rresp_i != 2'b00 ? CPL_CA : CPL_SC;
                uncor_d  = m_axi_rresp_i != 2'b00;
                state_d  = CPL;
            end
            CPL: state_d = tx_cpl_tlp_ready_i ? IDLE : CPL;
            default: state_d = IDLE;
        endcase
        ready_d = state_q == IDLE && state_d == IDLE;
    end

    // state and captured request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            hdr_q     <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            status_q  <= CPL_SC;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cor_q     <= 1'b0;
            uncor_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            hdr_q     <= hdr_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            status_q  <= status_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cor_q     <= cor_d;
            uncor_q   <= uncor_d;
        end
    end

    // byte strobes of the payload once realigned to its DW offset in the 32-byte beat
    always_comb begin
        wstrb_c = '0;
        for (int i = 0; i < AXI_STRB_WIDTH / 4; i++)
            wstrb_c[i*4 +: 4] = (i < int'(q_lo[2:0]) || i >= int'(q_lo[2:0]) + int'(q_len)) ? 4'h0 :
                                (i == int'(q_lo[2:0])) ? hdr_fbe(hdr_q) :
                                (i == int'(q_lo[2:0]) + int'(q_len) - 1) ? hdr_lbe(hdr_q) : 4'hF;
    end

    assign ax_fields = {{AXI_ID_WIDTH{1'b0}}, AXI_ADDR_WIDTH'(hdr_addr(hdr_q) & ~64'h1f),
                        8'd0, 3'd5, 2'b01, 1'b0, 4'b0011, 3'b010};

    assign m_axi_awvalid_o = state_q == WR_ADDR_DATA && !aw_done_q;
    assign m_axi_wvalid_o  = state_q == WR_ADDR_DATA && !w_done_q;
    assign m_axi_arvalid_o = state_q == RD_ADDR;
    assign m_axi_bready_o  = state_q == WR_RESP;
    assign m_axi_rready_o  = state_q == RD_DATA;
    assign {m_axi_awid_o, m_axi_awaddr_o, m_axi_awlen_o, m_axi_awsize_o, m_axi_awburst_o,
            m_axi_awlock_o, m_axi_awcache_o, m_axi_awprot_o} = m_axi_awvalid_o ? ax_fields : '0;
    assign {m_axi_arid_o, m_axi_araddr_o, m_axi_arlen_o, m_axi_arsize_o, m_axi_arburst_o,
            m_axi_arlock_o, m_axi_arcache_o, m_axi_arprot_o} = m_axi_arvalid_o ? ax_fields : '0;
    assign m_axi_wdata_o = m_axi_wvalid_o ? AXI_DATA_WIDTH'(data_q << {q_lo[2:0], 5'b0}) : '0;
    assign m_axi_wstrb_o = m_axi_wvalid_o ? wstrb_c : '0;
    assign m_axi_wlast_o = m_axi_wvalid_o;

    pcie_cpl_builder #(
        .HDR_W  (TLP_HDR_WIDTH),
        .DATA_W (TLP_DATA_WIDTH),
        .STRB_W (TLP_STRB_WIDTH)
    ) u_cpl_builder (
        .req_hdr_i      (hdr_q),
        .status_i       (status_q),
        .rdata_i        (rdata_q),
        .completer_id_i (completer_id_i),
        .cpl_hdr_o      (cpl_hdr),
        .cpl_data_o     (cpl_data),
        .cpl_strb_o     (cpl_strb)
    );

`ifdef PCIE_BRIDGE_CXLIO_MCTP_EN
    logic                      mctp_full_q, mctp_full_d;
    logic [TLP_HDR_WIDTH-1:0]  mctp_hdr_q, mctp_hdr_d;
    logic [TLP_DATA_WIDTH-1:0] mctp_data_q, mctp_data_d;
    logic                      mctp_sel;
    logic                      unused_mctp;

    assign unused_mctp = ^cxlio_mctp_rsp_pkt_i;
    assign mctp_sel    = !cpl_sel && mctp_full_q;
    assign mctp_drop   = cxlio_mctp_en_i && mctp_full_q;

    // a full buffer only empties on its own handshake; new packets are taken only when empty
    always_comb begin
        mctp_full_d = mctp_full_q ? !(mctp_sel && tx_cpl_tlp_ready_i) : cxlio_mctp_en_i;
        mctp_hdr_d  = (!mctp_full_q && cxlio_mctp_en_i) ? cxlio_mctp_req_hdr_i : mctp_hdr_q;
        mctp_data_d = (!mctp_full_q && cxlio_mctp_en_i) ? cxlio_mctp_req_data_i : mctp_data_q;
    end

    // MCTP buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mctp_full_q <= 1'b0;
            mctp_hdr_q  <= '0;
            mctp_data_q <= '0;
        end else begin
            mctp_full_q <= mctp_full_d;
            mctp_hdr_q  <= mctp_hdr_d;
            mctp_data_q <= mctp_data_d;
        end
    end

    assign tx_valid = cpl_sel | mctp_sel;
    assign tx_hdr   = cpl_sel ? cpl_hdr : mctp_sel ? mctp_hdr_q : '0;
    assign tx_data  = cpl_sel ? cpl_data : mctp_sel ? mctp_data_q : '0;
    assign tx_strb  = cpl_sel ? cpl_strb : mctp_sel ? {TLP_STRB_WIDTH{1'b1}} : '0;
`else
    assign mctp_drop = 1'b0;
    assign tx_valid  = cpl_sel;
    assign tx_hdr    = cpl_sel ? cpl_hdr : '0;
    assign tx_data   = cpl_sel ? cpl_data : '0;
    assign tx_strb   = cpl_sel ? cpl_strb : '0;
`endif

    assign tx_cpl_tlp_valid_o   = {TLP_SEG_COUNT{tx_valid}};
    assign tx_cpl_tlp_sop_o     = {TLP_SEG_COUNT{tx_valid}};
    assign tx_cpl_tlp_eop_o     = {TLP_SEG_COUNT{tx_valid}};
    assign tx_cpl_tlp_hdr_o     = tx_hdr;
    assign tx_cpl_tlp_data_o    = tx_data;
    assign tx_cpl_tlp_strb_o    = tx_strb;
    assign rx_req_tlp_ready_o   = ready_q;
    assign status_error_cor_o   = cor_q;
    assign status_error_uncor_o = uncor_q;

endmodule

// File: tb/tb_pcie_modport_bridge.sv
// tb_pcie_modport_bridge: directed vectors with hand-computed expectations for pcie_modport_bridge
module tb_pcie_modport_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] rx_data;
    logic [127:0] rx_hdr;
    logic         rx_valid, rx_sop, rx_eop, rx_ready;
    logic [255:0] tx_data;
    logic [7:0]   tx_strb;
    logic [127:0] tx_hdr;
    logic         tx_valid, tx_sop, tx_eop, tx_ready;
    logic [15:0]  completer_id;
    logic [2:0]   mps;
    logic         err_cor, err_uncor;
    logic [7:0]   awid, awlen, arid, arlen, bid, rid;
    logic [63:0]  awaddr, araddr;
    logic [2:0]   awsize, awprot, arsize, arprot;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awlock, arlock, awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic         arvalid, arready, rvalid, rready, rlast;
    logic [3:0]   awcache, arcache;
    logic [255:0] wdata, rdata;
    logic [31:0]  wstrb;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pcie_modport_bridge dut (
        .clk(clk), .rst(rst),
        .rx_req_tlp_data_i(rx_data), .rx_req_tlp_hdr_i(rx_hdr), .rx_req_tlp_valid_i(rx_valid),
        .rx_req_tlp_sop_i(rx_sop), .rx_req_tlp_eop_i(rx_eop), .rx_req_tlp_ready_o(rx_ready),
        .tx_cpl_tlp_data_o(tx_data), .tx_cpl_tlp_strb_o(tx_strb), .tx_cpl_tlp_hdr_o(tx_hdr),
        .tx_cpl_tlp_valid_o(tx_valid), .tx_cpl_tlp_sop_o(tx_sop), .tx_cpl_tlp_eop_o(tx_eop),
        .tx_cpl_tlp_ready_i(tx_ready), .completer_id_i(completer_id), .max_payload_size_i(mps),
        .status_error_cor_o(err_cor), .status_error_uncor_o(err_uncor),
        .m_axi_awid_o(awid), .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen), .m_axi_awsize_o(awsize),
        .m_axi_awburst_o(awburst), .m_axi_awlock_o(awlock), .m_axi_awcache_o(awcache),
        .m_axi_awprot_o(awprot), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
        .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast), .m_axi_wvalid_o(wvalid),
        .m_axi_wready_i(wready), .m_axi_bid_i(bid), .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid),
        .m_axi_bready_o(bready), .m_axi_arid_o(arid), .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen),
        .m_axi_arsize_o(arsize), .m_axi_arburst_o(arburst), .m_axi_arlock_o(arlock),
        .m_axi_arcache_o(arcache), .m_axi_arprot_o(arprot), .m_axi_arvalid_o(arvalid),
        .m_axi_arready_i(arready), .m_axi_rid_i(rid), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp),
        .m_axi_rlast_i(rlast), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_hdr(input logic [2:0] fmt, input logic [9:0] len,
                                            input logic [7:0] tag, input logic [3:0] lbe,
                                            input logic [3:0] fbe, input logic [63:0] addr);
        logic [127:0] h;
        h = '0;
        h[127:125] = fmt;
        h[105:96]  = len;
        h[95:80]   = 16'h0100;
        h[79:72]   = tag;
        h[71:68]   = lbe;
        h[67:64]   = fbe;
        if (fmt[0]) begin
            h[63:32] = addr[63:32];
            h[31:0]  = addr[31:0];
        end else begin
            h[63:32] = addr[31:0];
        end
        return h;
    endfunction

    // waits (bounded) for ready, presents one TLP, returns at the negedge after acceptance
    task automatic send(input string t, input logic [127:0] h, input logic [255:0] d);
        for (int i = 0; i < 20 && !rx_ready; i++) @(negedge clk);
        chk({t, "_rx_ready"}, rx_ready, 1);
        rx_hdr = h; rx_data = d; rx_valid = 1; rx_sop = 1; rx_eop = 1;
        @(negedge clk);
        rx_valid = 0; rx_sop = 0; rx_eop = 0;
    endtask

    task automatic wr_txn(input string t, input logic [127:0] h, input logic [255:0] d,
                          input logic [63:0] ea, input logic [31:0] es, input logic [255:0] ew,
                          input logic w_first, input logic [1:0] br);
        send(t, h, d);
        chk({t, "_awvalid"}, awvalid, 1);
        chk({t, "_awaddr"}, awaddr, ea);
        chk({t, "_awattr"}, {awid, awlen, awsize, awburst, awlock, awcache, awprot},
            {8'd0, 8'd0, 3'd5, 2'b01, 1'b0, 4'b0011, 3'b010});
        chk({t, "_wvalid"}, wvalid, 1);
        chk({t, "_wstrb"}, wstrb, es);
        chk({t, "_wdata"}, wdata, ew);
        chk({t, "_wlast"}, wlast, 1);
        if (w_first) wready = 1; else awready = 1;
        @(negedge clk);
        chk({t, "_aw_hold"}, awvalid, w_first);
        chk({t, "_w_hold"}, wvalid, !w_first);
        chk({t, "_bready_early"}, bready, 0);
        awready = !awready; wready = !wready;
        @(negedge clk);
        awready = 0; wready = 0;
        chk({t, "_ch_done"}, {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1; bresp = br;
        @(negedge clk);
        bvalid = 0; bresp = 0;
        chk({t, "_post_b"}, {bready, rx_ready, tx_valid}, 3'b000);
        chk({t, "_b_err"}, err_uncor, br != 2'b00);
        @(negedge clk);
        chk({t, "_ready_back"}, {rx_ready, err_uncor}, 2'b10);
    endtask

    // runs a read through AR and R; returns at the negedge where the completion is first visible
    task automatic rd_txn(input string t, input logic [127:0] h, input logic [63:0] ea,
                          input logic [255:0] rd, input logic [1:0] rr);
        send(t, h, '0);
        chk({t, "_arvalid"}, arvalid, 1);
        chk({t, "_araddr"}, araddr, ea);
        chk({t, "_arattr"}, {arlen, arsize, arburst, arcache, arprot},
            {8'd0, 3'd5, 2'b01, 4'b0011, 3'b010});
        arready = 1;
        @(negedge clk);
        arready = 0;
        chk({t, "_rready"}, {arvalid, rready, tx_valid}, 3'b010);
        rvalid = 1; rdata = rd; rresp = rr; rlast = 1;
        @(negedge clk);
        rvalid = 0; rresp = 0; rlast = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; rx_data = '0; rx_hdr = '0; rx_valid = 0; rx_sop = 0; rx_eop = 0; tx_ready = 0;
        completer_id = 16'hABCD; mps = 3'd0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        arready = 0; rid = 0; rdata = '0; rresp = 0; rlast = 0; rvalid = 0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {rx_ready, tx_valid, awvalid, wvalid, arvalid, bready, rready, err_cor, err_uncor},
            9'b0);
        chk("rst_axi_fields", {awsize, awburst, awcache, awprot, wlast, tx_hdr[127:96]}, '0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_rst", rx_ready, 1);

        wr_txn("mwr3dw", mk_hdr(3'b010, 10'd2, 8'd1, 4'hF, 4'hF, 64'h1004), 256'h0000000B_0000000A,
               64'h1000, 32'h00000FF0, 256'h0000000B_0000000A_00000000, 1'b0, 2'b00);

        wr_txn("mwr_be", mk_hdr(3'b010, 10'd3, 8'd2, 4'h3, 4'hC, 64'h1008),
               256'h00000003_00000002_00000001, 64'h1000, 32'h0003FC00,
               256'h00000003_00000002_00000001_00000000_00000000, 1'b1, 2'b10);

        rd_txn("mrd4dw", mk_hdr(3'b001, 10'd1, 8'd5, 4'h0, 4'hF, 64'h1_0000_0008), 64'h1_0000_0000,
               256'h11111111_DEADBEEF_00000000_00000000, 2'b00);
        chk("cpld_valid", {tx_valid, tx_sop, tx_eop}, 3'b111);
        chk("cpld_hdr", tx_hdr, {32'h4A000001, 32'hABCD0004, 32'h01000508, 32'h0});
        chk("cpld_data", tx_data, 256'h11111111_DEADBEEF);
        chk("cpld_strb", tx_strb, 8'h01);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_fields", {tx_valid, rx_ready, tx_strb, tx_hdr, tx_data[63:0]},
                {1'b1, 1'b0, 8'h01, 32'h4A000001, 32'hABCD0004, 32'h01000508, 32'h0,
                 64'h11111111_DEADBEEF});
        end
        tx_ready = 1;
        @(negedge clk);
        tx_ready = 0;
        chk("cpld_done", {tx_valid, rx_ready}, 2'b00);
        @(negedge clk);
        chk("cpld_ready_back", rx_ready, 1);

        rd_txn("mrd_ca", mk_hdr(3'b000, 10'd1, 8'd7, 4'h0, 4'hF, 64'h2000), 64'h2000,
               256'h12345678, 2'b10);
        chk("ca_hdr", tx_hdr, {32'h0A000000, 32'hABCD8004, 32'h01000700, 32'h0});
        chk("ca_strb_data", {tx_strb, tx_data}, '0);
        chk("ca_err", {err_uncor, err_cor}, 2'b10);
        tx_ready = 1;
        @(negedge clk);
        tx_ready = 0;
        chk("ca_err_one_cycle", {err_uncor, tx_valid}, 2'b00);

        send("mrd_ur", mk_hdr(3'b000, 10'd9, 8'd9, 4'hF, 4'hF, 64'h3000), '0);
        chk("ur_no_axi", {arvalid, awvalid, wvalid}, 3'b000);
        chk("ur_valid", tx_valid, 1);
        chk("ur_hdr", tx_hdr, {32'h0A000000, 32'hABCD2024, 32'h01000900, 32'h0});
        chk("ur_err", {err_cor, err_uncor}, 2'b10);
        @(negedge clk);
        chk("ur_err_one_cycle", {err_cor, arvalid}, 2'b00);
        tx_ready = 1;
        @(negedge clk);
        tx_ready = 0;

        send("mwr_bad", mk_hdr(3'b010, 10'd8, 8'd3, 4'hF, 4'hF, 64'h4004), '1);
        chk("bad_wr_drop", {awvalid, wvalid, tx_valid}, 3'b000);
        chk("bad_wr_err", {err_uncor, err_cor, rx_ready}, 3'b101);
        @(negedge clk);
        chk("bad_wr_err_one_cycle", err_uncor, 0);

        send("mrd_rst", mk_hdr(3'b000, 10'd1, 8'd4, 4'h0, 4'hF, 64'h5000), '0);
        arready = 1;
        @(negedge clk);
        arready = 0;
        chk("rst_mid_rready", rready, 1);
        #2 rst = 1;
        #1 chk("rst_mid_async", {rready, arvalid, rx_ready, tx_valid, err_cor, err_uncor}, 6'b0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_mid_after", {tx_valid, rready, rx_ready}, 3'b001);
        wr_txn("mwr_post_rst", mk_hdr(3'b010, 10'd1, 8'd6, 4'h0, 4'h3, 64'h6010), 256'h00000055,
               64'h6000, 32'h00030000, 256'h00000055_00000000_00000000_00000000_00000000, 1'b0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
